// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Resolves RAW hazards by forwarding. Handles load-use and branch hazards with
// stalls and flushes. Freezes the back end while data memory is busy, and
// latches a sticky timeout error if memory never answers.

module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH     = 5,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_d,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_w,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_regwrite_m,
  input  logic                  i_regwrite_w,
  input  logic                  i_pcsrc_e,
  input  logic                  i_dmem_req_m,
  input  logic                  i_dmem_ready,
  output logic [1:0]            o_forward_a_e,
  output logic [1:0]            o_forward_b_e,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_stall_e,
  output logic                  o_stall_m,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic                  o_flush_w,
  output logic                  o_timeout,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

  // Memory-wait FSM states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  // Last wait-counter value tolerated before memory is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // A result-select value of 01 marks the EX instruction as a load.
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  state_t                state_q;
  state_t                state_n;
  logic [7:0]            wait_cnt_q;
  logic                  timeout_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic [CNT_WIDTH-1:0]  flush_cnt_q;

  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  load_use;
  logic                  mem_miss;
  logic                  in_error;
  logic                  mem_stall;
  logic                  stall_front;
  logic                  flush_dec;
  logic                  flush_exe;

  // Operand A bypass: the younger producer in M beats the older one in W.
  always_comb begin
    forward_a = 2'b00;
    if (i_regwrite_m && (i_rd_addr_m != '0) && (i_rd_addr_m == i_rs1_addr_e)) begin
      forward_a = 2'b10;
    end else if (i_regwrite_w && (i_rd_addr_w != '0) && (i_rd_addr_w == i_rs1_addr_e)) begin
      forward_a = 2'b01;
    end
  end

  // Operand B bypass, same priority as operand A.
  always_comb begin
    forward_b = 2'b00;
    if (i_regwrite_m && (i_rd_addr_m != '0) && (i_rd_addr_m == i_rs2_addr_e)) begin
      forward_b = 2'b10;
    end else if (i_regwrite_w && (i_rd_addr_w != '0) && (i_rd_addr_w == i_rs2_addr_e)) begin
      forward_b = 2'b01;
    end
  end

  // A load in EX whose destination is read by the decode instruction cannot be bypassed in time.
  always_comb begin
    load_use = 1'b0;
    if ((i_resultsrc_e == RESULT_LOAD) && (i_rd_addr_e != '0) &&
        ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d))) begin
      load_use = 1'b1;
    end
  end

  // FSM state register; reset forces RUN immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next state: enter WAIT on a miss, leave when memory answers, give up after the wait budget.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_dmem_req_m && !i_dmem_ready) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_dmem_ready) begin
          state_n = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_n = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_n = ST_ERROR;
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // FSM outputs: ERROR freezes the pipe like an endless miss. While reset is held, only the live miss counts.
  always_comb begin
    mem_miss  = i_dmem_req_m && !i_dmem_ready;
    in_error  = (state_q == ST_ERROR) && !i_rst;
    mem_stall = mem_miss || in_error;
  end

  // Stall and flush combination: a memory stall masks every flush except the W bubble.
  always_comb begin
    stall_front = load_use || mem_stall;
    flush_dec   = i_pcsrc_e && !mem_stall;
    flush_exe   = (load_use || i_pcsrc_e) && !mem_stall;
  end

  // Wait counter: counts unanswered WAIT cycles and is zeroed whenever the pipe runs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN:  wait_cnt_q <= 8'd0;
        ST_WAIT: wait_cnt_q <= i_dmem_ready ? 8'd0 : (wait_cnt_q + 8'd1);
        default: wait_cnt_q <= wait_cnt_q;
      endcase
    end
  end

  // Sticky timeout flag, kept in step with the ERROR state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_n == ST_ERROR);
    end
  end

  // Stall performance counter: counts front-end stall cycles and saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (stall_front && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Flush performance counter: counts decode flushes (taken branches) and saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flush_cnt_q <= '0;
    end else if (flush_dec && (flush_cnt_q != '1)) begin
      flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_forward_a_e = forward_a;
  assign o_forward_b_e = forward_b;
  assign o_stall_f     = stall_front;
  assign o_stall_d     = stall_front;
  assign o_stall_e     = mem_stall;
  assign o_stall_m     = mem_stall;
  assign o_flush_d     = flush_dec;
  assign o_flush_e     = flush_exe;
  assign o_flush_w     = mem_stall;
  assign o_timeout     = timeout_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with a short timeout and narrow counters.

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] resultsrc_e;
  logic       regwrite_m, regwrite_w, pcsrc_e, dmem_req_m, dmem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, timeout;
  logic [3:0] stall_cnt, flush_cnt;

  int total;
  int bad;

  pipeline_hazard_ctrl #(
    .ADDR_WIDTH(5),
    .CNT_WIDTH(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rs1_addr_d(rs1_d),
    .i_rs2_addr_d(rs2_d),
    .i_rs1_addr_e(rs1_e),
    .i_rs2_addr_e(rs2_e),
    .i_rd_addr_e(rd_e),
    .i_rd_addr_m(rd_m),
    .i_rd_addr_w(rd_w),
    .i_resultsrc_e(resultsrc_e),
    .i_regwrite_m(regwrite_m),
    .i_regwrite_w(regwrite_w),
    .i_pcsrc_e(pcsrc_e),
    .i_dmem_req_m(dmem_req_m),
    .i_dmem_ready(dmem_ready),
    .o_forward_a_e(fwd_a),
    .o_forward_b_e(fwd_b),
    .o_stall_f(stall_f),
    .o_stall_d(stall_d),
    .o_stall_e(stall_e),
    .o_stall_m(stall_m),
    .o_flush_d(flush_d),
    .o_flush_e(flush_e),
    .o_flush_w(flush_w),
    .o_timeout(timeout),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; resultsrc_e = 2'b00;
    regwrite_m = 1'b0; regwrite_w = 1'b0; pcsrc_e = 1'b0;
    dmem_req_m = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    #2;
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout got=%0b want=0", timeout); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rst_stall_cnt got=%0d want=0", stall_cnt); end
    total++; if (flush_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rst_flush_cnt got=%0d want=0", flush_cnt); end
    total++; if ({stall_f, stall_e, flush_d, flush_e, flush_w} !== 5'b0) begin bad++; $display("[TB] FAIL rst_idle_ctl got=%b want=00000", {stall_f, stall_e, flush_d, flush_e, flush_w}); end
    resultsrc_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9;
    #1;
    total++; if (stall_f !== 1'b1) begin bad++; $display("[TB] FAIL rst_comb_lu got=%0b want=1", stall_f); end
    tick();
    tick();
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rst_cnt_frozen got=%0d want=0", stall_cnt); end
    set_idle();
    rst = 1'b0;
    tick();
    total++; if ({stall_f, timeout, stall_cnt} !== 6'b0) begin bad++; $display("[TB] FAIL rst_release got=%b want=000000", {stall_f, timeout, stall_cnt}); end
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1_e = 5'd5; rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
    #1;
    total++; if (fwd_a !== 2'b10) begin bad++; $display("[TB] FAIL fwd_a_mem got=%b want=10", fwd_a); end
    rd_m = 5'd0;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("[TB] FAIL fwd_a_wb got=%b want=01", fwd_a); end
    rs1_e = 5'd0;
    #1;
    total++; if (fwd_a !== 2'b00) begin bad++; $display("[TB] FAIL fwd_a_x0 got=%b want=00", fwd_a); end
    rs2_e = 5'd3; rd_m = 5'd3; regwrite_m = 1'b0; rd_w = 5'd3; regwrite_w = 1'b1;
    #1;
    total++; if (fwd_b !== 2'b01) begin bad++; $display("[TB] FAIL fwd_b_wb got=%b want=01", fwd_b); end
    regwrite_m = 1'b1;
    #1;
    total++; if (fwd_b !== 2'b10) begin bad++; $display("[TB] FAIL fwd_b_mem got=%b want=10", fwd_b); end
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    #1;
    total++; if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("[TB] FAIL fwd_no_we got=%b want=0000", {fwd_a, fwd_b}); end
  endtask

  task automatic test_load_use();
    do_reset();
    resultsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; rs1_d = 5'd2;
    #1;
    total++; if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin bad++; $display("[TB] FAIL lu_ctl got=%b want=1110", {stall_f, stall_d, flush_e, flush_d}); end
    total++; if ({stall_e, stall_m, flush_w} !== 3'b000) begin bad++; $display("[TB] FAIL lu_back got=%b want=000", {stall_e, stall_m, flush_w}); end
    tick();
    set_idle();
    #1;
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("[TB] FAIL lu_stall_cnt got=%0d want=1", stall_cnt); end
    resultsrc_e = 2'b00; rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    total++; if (stall_f !== 1'b0) begin bad++; $display("[TB] FAIL lu_not_load got=%0b want=0", stall_f); end
    resultsrc_e = 2'b01; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
    #1;
    total++; if (stall_f !== 1'b0) begin bad++; $display("[TB] FAIL lu_x0 got=%0b want=0", stall_f); end
  endtask

  task automatic test_branch();
    do_reset();
    pcsrc_e = 1'b1;
    #1;
    total++; if ({flush_d, flush_e, stall_f} !== 3'b110) begin bad++; $display("[TB] FAIL br_ctl got=%b want=110", {flush_d, flush_e, stall_f}); end
    tick();
    pcsrc_e = 1'b0;
    #1;
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("[TB] FAIL br_flush_cnt got=%0d want=1", flush_cnt); end
    total++; if ({flush_d, flush_e} !== 2'b00) begin bad++; $display("[TB] FAIL br_one_cycle got=%b want=00", {flush_d, flush_e}); end
    pcsrc_e = 1'b1; resultsrc_e = 2'b01; rd_e = 5'd4; rs1_d = 5'd4;
    #1;
    total++; if ({stall_f, flush_d, flush_e} !== 3'b111) begin bad++; $display("[TB] FAIL br_and_lu got=%b want=111", {stall_f, flush_d, flush_e}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pcsrc_e = 1'b1;
    tick();
    tick();
    pcsrc_e = 1'b0;
    #1;
    total++; if (flush_cnt !== 4'd2) begin bad++; $display("[TB] FAIL b2b_flush_cnt got=%0d want=2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    int stall_cycles;
    do_reset();
    stall_cycles = 0;
    dmem_req_m = 1'b1; dmem_ready = 1'b0; pcsrc_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if ({stall_f, stall_d, stall_e, stall_m, flush_w} == 5'b11111) stall_cycles++;
      total++; if ({flush_d, flush_e} !== 2'b00) begin bad++; $display("[TB] FAIL mw_flush_masked cyc=%0d got=%b want=00", i, {flush_d, flush_e}); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    total++; if ({stall_f, stall_e, stall_m, flush_w} !== 4'b0000) begin bad++; $display("[TB] FAIL mw_release got=%b want=0000", {stall_f, stall_e, stall_m, flush_w}); end
    total++; if (flush_d !== 1'b1) begin bad++; $display("[TB] FAIL mw_branch_after got=%0b want=1", flush_d); end
    total++; if (stall_cycles !== 3) begin bad++; $display("[TB] FAIL mw_stall_cycles got=%0d want=3", stall_cycles); end
    tick();
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("[TB] FAIL mw_stall_cnt got=%0d want=3", stall_cnt); end
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("[TB] FAIL mw_flush_cnt got=%0d want=1", flush_cnt); end
    set_idle();
    for (int i = 0; i < 6; i++) tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL mw_back_in_run got=%0b want=0", timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      total++; if ({stall_f, stall_e, flush_w} !== 3'b111) begin bad++; $display("[TB] FAIL to_stall cyc=%0d got=%b want=111", i, {stall_f, stall_e, flush_w}); end
      tick();
      total++; if (timeout !== (i == 5)) begin bad++; $display("[TB] FAIL to_flag cyc=%0d got=%0b want=%0b", i, timeout, (i == 5)); end
    end
    dmem_req_m = 1'b0; dmem_ready = 1'b1; pcsrc_e = 1'b1;
    #1;
    total++; if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d} !== 6'b111110) begin bad++; $display("[TB] FAIL to_error_hold got=%b want=111110", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d}); end
    tick();
    tick();
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky got=%0b want=1", timeout); end
    set_idle();
    rst = 1'b1;
    #1;
    total++; if ({timeout, stall_f, stall_cnt} !== 6'b0) begin bad++; $display("[TB] FAIL to_rst_async got=%b want=000000", {timeout, stall_f, stall_cnt}); end
    tick();
    rst = 1'b0;
    tick();
    total++; if ({timeout, stall_f, stall_e} !== 3'b000) begin bad++; $display("[TB] FAIL to_after_rst got=%b want=000", {timeout, stall_f, stall_e}); end
  endtask

  task automatic test_saturation();
    do_reset();
    resultsrc_e = 2'b01; rd_e = 5'd11; rs1_d = 5'd11;
    for (int i = 0; i < 10; i++) tick();
    total++; if (stall_cnt !== 4'd10) begin bad++; $display("[TB] FAIL sat_mid got=%0d want=10", stall_cnt); end
    for (int i = 0; i < 10; i++) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("[TB] FAIL sat_top got=%0d want=15", stall_cnt); end
    tick();
    tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold got=%0d want=15", stall_cnt); end
    set_idle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    set_idle();
    rst = 1'b1;
    #3;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, performance counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum consecutive data-memory wait cycles (1..255).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports in this order:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_rs1_addr_d, i_rs2_addr_d  in  ADDR_WIDTH  decode-stage source registers.
- i_rs1_addr_e, i_rs2_addr_e, i_rd_addr_e  in  ADDR_WIDTH  execute-stage register fields.
- i_rd_addr_m, i_rd_addr_w  in  ADDR_WIDTH  memory- and writeback-stage destinations.
- i_resultsrc_e  in  2  execute-stage result select; 2'b01 marks a load.
- i_regwrite_m, i_regwrite_w  in  1  register write enables for the M and W stages.
- i_pcsrc_e  in  1  branch or jump taken in EX.
- i_dmem_req_m  in  1  data-memory access in M.
- i_dmem_ready  in  1  data memory completes this cycle.
- o_forward_a_e, o_forward_b_e  out  2  ALU operand select: 00 regfile, 01 W result, 10 M ALU result.
- o_stall_f, o_stall_d, o_stall_e, o_stall_m  out  1  hold stage register.
- o_flush_d, o_flush_e, o_flush_w  out  1  insert bubble into stage register.
- o_timeout  out  1  sticky memory-timeout error.
- o_stall_cnt, o_flush_cnt  out  CNT_WIDTH  performance counters.

Function
REQ-005 SHALL compute forward_a combinationally in this order:
- 10 if i_regwrite_m, i_rd_addr_m!=0 and i_rd_addr_m==i_rs1_addr_e;
- else 01 if i_regwrite_w, i_rd_addr_w!=0 and i_rd_addr_w==i_rs1_addr_e;
- else 00.
REQ-006 SHALL compute forward_b identically using i_rs2_addr_e.
REQ-007 SHALL raise load-use (lu) when i_resultsrc_e==2'b01, i_rd_addr_e!=0 and i_rd_addr_e matches i_rs1_addr_d or i_rs2_addr_d.
REQ-008 SHALL raise memory stall (ms) when i_dmem_req_m && !i_dmem_ready, or when the state is ERROR.
REQ-009 SHALL drive o_stall_f = o_stall_d = lu | ms.
REQ-010 SHALL drive o_stall_e = o_stall_m = ms.
REQ-011 SHALL drive o_flush_w = ms.
REQ-012 SHALL drive o_flush_d = i_pcsrc_e & !ms.
REQ-013 SHALL drive o_flush_e = (lu | i_pcsrc_e) & !ms.
- Priority: ms over branch flush over lu; lu and branch flush may assert together.
REQ-014 SHALL implement a registered FSM with states RUN, WAIT and ERROR.
REQ-015 SHALL transition RUN->WAIT when i_dmem_req_m && !i_dmem_ready.
REQ-016 SHALL transition WAIT->RUN when i_dmem_ready.
REQ-017 SHALL transition WAIT->ERROR when the wait counter equals TIMEOUT_CYCLES-1 and !i_dmem_ready.
REQ-018 SHALL hold ERROR until reset.
REQ-019 SHALL keep an 8-bit wait counter: cleared in RUN, incremented each WAIT cycle with !i_dmem_ready, cleared on WAIT->RUN.
REQ-020 SHALL drive o_timeout = (state==ERROR), registered.
REQ-021 SHALL increment o_stall_cnt on each cycle with o_stall_f=1 and saturate at all-ones.
REQ-022 SHALL increment o_flush_cnt on each cycle with o_flush_d=1 and saturate at all-ones.
REQ-023 SHALL have zero latency on all stall, flush and forward outputs (combinational from the same-cycle inputs and the registered state).

Reset
REQ-024 SHALL, on i_rst=1 and regardless of the clock, set the state to RUN and clear the wait counter, o_timeout, o_stall_cnt and o_flush_cnt.
REQ-025 SHALL, during reset, still drive the combinational outputs from inputs; ms then excludes the ERROR term.
REQ-026 SHALL make an i_rst assertion during WAIT or ERROR return the FSM to RUN on the first clock edge after deassertion.

Verification
REQ-027 Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> forward_a=10; with rd_m=0 -> 01; with rs1_e=0 -> 00.
REQ-028 Load-use: resultsrc_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0; stall_cnt increments by 1.
REQ-029 Branch: pcsrc_e=1, no lu -> flush_d=flush_e=1 for one cycle; flush_cnt=1.
REQ-030 Memory wait: dmem_req_m=1, ready low 3 cycles then high -> stall_f/d/e/m and flush_w high exactly 3 cycles, FSM back in RUN; pcsrc_e=1 during the wait -> flush_d=0.
REQ-031 Timeout: TIMEOUT_CYCLES=4, ready held low -> o_timeout=1 after the 5th wait cycle and all stalls stay high; raising ready has no effect; i_rst pulse clears everything.
REQ-032 Saturation: CNT_WIDTH=4, lu held 20 cycles -> stall_cnt=15 and holds.
